// File: rtl/alu_seq_pkg.sv
// Shared constants for the sequential ALU/multiplier: ALU opcodes and controller states.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [5:0] FULL_STEPS = 6'd32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between a requester (master) and the alu_seq block (slave).
interface alu_seq_if;
  logic        start;
  logic        mode;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  modport master (
    output start, mode, op, a, b,
    input  ready, busy, done, result, zero
  );

  modport slave (
    input  start, mode, op, a, b,
    output ready, busy, done, result, zero
  );
endinterface

// File: rtl/alu_seq_alu.sv
// Combinational 32-bit ALU private to alu_seq; unknown opcodes produce zero.
module alu
  import alu_seq_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] y_o
);

  // Opcode decode; set-less-than compares unsigned
  always_comb begin
    y_o = 32'd0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_SLT:  y_o = {31'd0, (a_i < b_i)};
      OP_NOR:  y_o = ~(a_i | b_i);
      default: y_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: one-shot ALU operation (mode 0) or shift-and-add 32-bit multiply (mode 1).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter logic EARLY_EXIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  state_e      state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [5:0]  step_q, step_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        ready_q, busy_q, done_q;

  logic [31:0] alu_a_s, alu_b_s, alu_y_s;
  logic [3:0]  alu_op_s;
  logic        run_end_s;

  alu u_alu (
    .a_i  (alu_a_s),
    .b_i  (alu_b_s),
    .op_i (alu_op_s),
    .y_o  (alu_y_s)
  );

  // Multiply termination: early on exhausted multiplier, or after the full 32 steps
  always_comb begin
    if (EARLY_EXIT) begin
      run_end_s = (mplier_q == 32'd0);
    end else begin
      run_end_s = (step_q == FULL_STEPS);
    end
  end

  // Next-state, datapath updates and ALU input selection
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    step_d   = step_q;
    result_d = result_q;
    zero_d   = zero_q;
    alu_a_s  = opa_q;
    alu_b_s  = opb_q;
    alu_op_s = op_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.mode) begin
            state_d  = ST_RUN;
            acc_d    = 32'd0;
            mcand_d  = bus.a;
            mplier_d = bus.b;
            step_d   = 6'd0;
          end else begin
            state_d = ST_EXEC;
            opa_d   = bus.a;
            opb_d   = bus.b;
            op_d    = bus.op;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d  = ST_DONE;
        result_d = alu_y_s;
        zero_d   = (alu_y_s == 32'd0);
      end
      ST_RUN: begin
        // The multiply reuses the same ALU as an accumulator adder
        alu_a_s  = acc_q;
        alu_b_s  = mcand_q;
        alu_op_s = OP_ADD;
        if (run_end_s) begin
          state_d  = ST_DONE;
          result_d = acc_q;
          zero_d   = (acc_q == 32'd0);
        end else begin
          if (mplier_q[0]) begin
            acc_d = alu_y_s;
          end else begin
            acc_d = acc_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          step_d   = step_q + 6'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      op_q     <= 4'd0;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      step_q   <= 6'd0;
      result_q <= 32'd0;
      zero_q   <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      step_q   <= step_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ready_q  <= (state_d == ST_IDLE);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: one instance with early exit, one with fixed 32-step multiply.
module tb_alu_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   sel;

  alu_seq_if if0 ();
  alu_seq_if if1 ();

  alu_seq #(.EARLY_EXIT(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  alu_seq #(.EARLY_EXIT(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        m_done, m_ready;
  logic [31:0] m_result;
  logic        m_zero;
  assign m_done   = sel ? if1.done   : if0.done;
  assign m_ready  = sel ? if1.ready  : if0.ready;
  assign m_result = sel ? if1.result : if0.result;
  assign m_zero   = sel ? if1.zero   : if0.zero;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit s, input logic mode, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input int exp_lat, input logic [31:0] exp_res,
                     input bit poke, input string tag);
    int lat;
    int extra;
    bit got;
    sel = s;
    @(negedge clk);
    chk({tag, ".ready_pre"}, {31'd0, m_ready}, 32'd1);
    if (s) begin
      if1.start = 1'b1; if1.mode = mode; if1.op = op; if1.a = a; if1.b = b;
    end else begin
      if0.start = 1'b1; if0.mode = mode; if0.op = op; if0.a = a; if0.b = b;
    end
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    if1.start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
      if (m_done) begin
        got = 1'b1;
      end else if (poke && lat == 1) begin
        if0.start = 1'b1; if0.mode = 1'b1; if0.a = 32'd9; if0.b = 32'd9;
      end else if (poke && lat == 2) begin
        if0.start = 1'b0;
      end
    end
    if0.start = 1'b0;
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".result"}, m_result, exp_res);
    chk({tag, ".zero"}, {31'd0, m_zero}, {31'd0, (exp_res == 32'd0)});
    @(posedge clk);
    #1;
    chk({tag, ".done_drop"}, {31'd0, m_done}, 32'd0);
    chk({tag, ".ready_back"}, {31'd0, m_ready}, 32'd1);
    if (poke) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        #1;
        if (m_done) extra++;
      end
      chk({tag, ".no_second_done"}, extra, 0);
      chk({tag, ".result_hold"}, m_result, exp_res);
    end
  endtask

  initial begin
    int pulses;
    checks = 0;
    errors = 0;
    sel = 1'b0;
    rst_n = 1'b0;
    if0.start = 1'b0; if0.mode = 1'b0; if0.op = 4'd0; if0.a = 32'd0; if0.b = 32'd0;
    if1.start = 1'b0; if1.mode = 1'b0; if1.op = 4'd0; if1.a = 32'd0; if1.b = 32'd0;
    #12;
    chk("rst.ready",  {31'd0, if0.ready}, 32'd1);
    chk("rst.busy",   {31'd0, if0.busy},  32'd0);
    chk("rst.done",   {31'd0, if0.done},  32'd0);
    chk("rst.result", if0.result,         32'd0);
    chk("rst.zero",   {31'd0, if0.zero},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 0 operations
    run(1'b0, 1'b0, 4'b0110, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 1'b0, "sub");
    run(1'b0, 1'b0, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'h00F0_1200, 1'b0, "and");
    run(1'b0, 1'b0, 4'b0001, 32'hF000_0000, 32'h0000_000F, 1, 32'hF000_000F, 1'b0, "or");
    run(1'b0, 1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd2, 1, 32'd1, 1'b0, "add_wrap");
    run(1'b0, 1'b0, 4'b0111, 32'd1, 32'd2, 1, 32'd1, 1'b0, "slt_true");
    run(1'b0, 1'b0, 4'b0111, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1'b0, "slt_unsigned");
    run(1'b0, 1'b0, 4'b1100, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1, 32'd0, 1'b0, "nor");
    run(1'b0, 1'b0, 4'b1101, 32'd0, 32'd1, 1, 32'h0000_0001 - 32'd1, 1'b0, "bad_op_seed");
    run(1'b0, 1'b0, 4'b0010, 32'd5, 32'd7, 1, 32'd12, 1'b0, "add");
    run(1'b0, 1'b0, 4'b0011, 32'd5, 32'd7, 1, 32'd0, 1'b0, "bad_op");

    // Multiply, early exit
    run(1'b0, 1'b1, 4'd0, 32'd6, 32'd7, 4, 32'd42, 1'b0, "mul_6x7");
    run(1'b0, 1'b1, 4'd0, 32'h0001_0000, 32'h0001_0000, 18, 32'd0, 1'b0, "mul_wrap");
    run(1'b0, 1'b1, 4'd0, 32'd123, 32'd0, 1, 32'd0, 1'b0, "mul_b0");
    run(1'b0, 1'b1, 4'd0, 32'd3, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFD, 1'b0, "mul_full");
    run(1'b0, 1'b1, 4'd0, 32'd6, 32'd7, 4, 32'd42, 1'b1, "mul_busy_start");

    // Multiply, fixed 32 steps
    run(1'b1, 1'b1, 4'd0, 32'd3, 32'd7, 33, 32'd21, 1'b0, "fix_3x7");
    run(1'b1, 1'b1, 4'd0, 32'd123, 32'd0, 33, 32'd0, 1'b0, "fix_b0");
    run(1'b1, 1'b0, 4'b0110, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, 1'b0, "fix_sub");

    // Reset in the middle of a multiply
    sel = 1'b0;
    run(1'b0, 1'b0, 4'b0010, 32'd100, 32'd1, 1, 32'd101, 1'b0, "pre_reset");
    @(negedge clk);
    if0.start = 1'b1; if0.mode = 1'b1; if0.a = 32'd6; if0.b = 32'd7;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    @(posedge clk);
    #1;
    chk("mid.busy_before", {31'd0, if0.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.ready",  {31'd0, if0.ready}, 32'd1);
    chk("mid.busy",   {31'd0, if0.busy},  32'd0);
    chk("mid.done",   {31'd0, if0.done},  32'd0);
    chk("mid.result", if0.result,         32'd0);
    chk("mid.zero",   {31'd0, if0.zero},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (if0.done) pulses++;
    end
    chk("mid.no_done", pulses, 0);
    run(1'b0, 1'b1, 4'd0, 32'd6, 32'd7, 4, 32'd42, 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter EARLY_EXIT, default 1, meaning 1 = multiply ends when the remaining multiplier is zero; 0 = always 32 step cycles.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request strobe; sampled only while ready=1.
REQ-005 mode  input  1  0 = single ALU operation; 1 = 32-bit multiply (low word).
REQ-006 op  input  4  ALU opcode for mode 0; ignored in mode 1.
REQ-007 a  input  32  operand A / multiplicand.
REQ-008 b  input  32  operand B / multiplier.
REQ-009 ready  output  1  high only in IDLE.
REQ-010 busy  output  1  high in EXEC, RUN and DONE.
REQ-011 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-012 result  output  32  registered result; holds until the next accepted request.
REQ-013 zero  output  1  registered; equals (result == 0).

Function
REQ-014 Accept: start=1 and ready=1 at a rising edge. Accept latches a, b, op and mode.
REQ-015 States:
- IDLE, EXEC, RUN, DONE.
- IDLE->EXEC on accept with mode=0.
- IDLE->RUN on accept with mode=1.
- EXEC->DONE unconditionally.
- RUN->DONE on the termination condition; otherwise RUN->RUN.
- DONE->IDLE unconditionally.
REQ-016 EXEC: drives the ALU with latched a, b and op; the ALU output is captured into result on the EXEC->DONE edge.
REQ-017 Supported opcodes:
- 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 unsigned set-less-than, 1100 NOR.
- Any other opcode yields 0.
REQ-018 On a mode-1 accept: acc=0, mcand=a, mplier=b.
REQ-019 Each RUN cycle with mplier!=0:
- if mplier[0]=1, acc <= ALU(acc, mcand, ADD);
- mcand <= mcand<<1; mplier <= mplier>>1; step count +1.
REQ-020 Termination, EARLY_EXIT=1: RUN->DONE on the first RUN cycle in which mplier==0; that cycle makes no update.
REQ-021 Termination, EARLY_EXIT=0: RUN->DONE after exactly 32 step cycles, regardless of mplier.
REQ-022 The multiply result is acc, captured on the RUN->DONE edge; the product is modulo 2^32 (ALU add wraps, no carry out).
REQ-023 Latency is counted in rising edges after the accept edge; done is high in the cycle after the last counted edge.
- Mode 0: 1 edge.
- Mode 1, EARLY_EXIT=1: k+1 edges, where k = (index of highest set bit of b)+1; k = 0 when b = 0.
- Mode 1, EARLY_EXIT=0: 33 edges.
REQ-024 done is high exactly while in DONE; ready goes high the cycle after done.
REQ-025 start while busy is ignored and does not alter the operation in progress.
REQ-026 An ALU unit shared with other logic is not permitted; the instance is private to this block.

Reset
REQ-027 rst_n=0 forces, asynchronously:
- state IDLE; ready=1; busy=0; done=0; result=0; zero=1;
- acc, mcand, mplier and step count all 0.
REQ-028 Reset during EXEC or RUN abandons the operation with no done pulse; the first accept after release behaves as from power-up.

Structure
REQ-029 The shared package holds the ALU opcode constants (AND, OR, ADD, SUB, SLT, NOR) and the state enumeration.
REQ-030 The block instantiates exactly one sub-module, alu; all other logic is local.

Verification
REQ-031 Reset asserted mid-RUN -> immediately ready=1, busy=0, done=0, result=0, zero=1; no done pulse afterwards.
REQ-032 Mode 0, op=0110, a=5, b=7 -> done 1 edge after accept; result=0xFFFFFFFE, zero=0.
REQ-033 Mode 1, a=6, b=7, EARLY_EXIT=1 -> done 4 edges after accept; result=42.
REQ-034 Mode 1, a=0x00010000, b=0x00010000 -> done 18 edges after accept; result=0 (wrap), zero=1.
REQ-035 Mode 1, a=123, b=0 -> done 1 edge after accept; result=0. Mode 1, a=3, b=0xFFFFFFFF -> done 33 edges after accept; result=0xFFFFFFFD.
REQ-036 start pulsed with a=9, b=9 during an active 6*7 multiply -> ignored; result=42; no second done.
